// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch FSM states, default reset vector.
package riscv_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding {PC, Instr, Valid}; squash loads a bubble and wins over write enable.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic            squash_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            valid_i,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (squash_i) begin
            pc_q    <= pc_i;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (we_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= valid_i;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding imem requests, and IF/ID register
// control so that stalls and flushes neither lose nor duplicate an instruction.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            IF_ID_Write,
    input  logic            Flush,
    input  logic [XLEN-1:0] BranchTarget,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [31:0]     IF_ID_Instr,
    output logic            IF_ID_Valid,
    output logic            fetch_busy
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic [31:0]     hold_q, hold_d;

    logic            adv;
    logic            deliver;
    logic            squash;
    logic [31:0]     instr_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        adv       = PCWrite & IF_ID_Write;
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        hold_d    = hold_q;
        deliver   = 1'b0;
        squash    = 1'b0;
        instr_sel = hold_q;

        if (Flush) begin
            pc_d   = BranchTarget;
            squash = 1'b1;
            // A request still in flight after this edge must have its response swallowed.
            if ((state_q == WAIT && !imem_rvalid) || (state_q == REQ && imem_ready)) begin
                state_d   = WAIT;
                discard_d = 1'b1;
            end else begin
                state_d   = REQ;
                discard_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                REQ: begin
                    if (imem_ready)
                        state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = REQ;
                        end else if (adv) begin
                            deliver   = 1'b1;
                            instr_sel = imem_rdata;
                            pc_d      = pc_q + XLEN'(4);
                            state_d   = REQ;
                        end else begin
                            hold_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (adv) begin
                        deliver = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    assign imem_req   = (state_q == REQ) & ~reset;
    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q == WAIT);

    // Without a delivered instruction an enabled write loads a bubble carrying the current PC.
    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .we_i     (IF_ID_Write),
        .squash_i (squash),
        .pc_i     (pc_q),
        .instr_i  (deliver ? instr_sel : NOP),
        .valid_i  (deliver),
        .pc_o     (IF_ID_PC),
        .instr_o  (IF_ID_Instr),
        .valid_o  (IF_ID_Valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with a transaction-level memory and fetch model.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCWrite = 1'b1, IF_ID_Write = 1'b1, Flush = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] IF_ID_PC, IF_ID_Instr;
    logic        IF_ID_Valid, fetch_busy;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PCWrite      (PCWrite),
        .IF_ID_Write  (IF_ID_Write),
        .Flush        (Flush),
        .BranchTarget (BranchTarget),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_Valid  (IF_ID_Valid),
        .fetch_busy   (fetch_busy)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // memory environment
    logic        mem_pend = 1'b0;
    int unsigned mem_cnt = 0;
    logic [31:0] mem_a = '0;
    int unsigned lat_lo = 0, lat_hi = 0;
    logic        stray_en = 1'b0;

    // reference model: in-flight flag, drop flag and a one-entry instruction buffer
    logic [31:0] m_pc = '0;
    logic        m_pending = 1'b0, m_discard = 1'b0, m_buf_valid = 1'b0;
    logic [31:0] m_buf = '0;
    logic [31:0] m_ifid_pc = '0, m_ifid_instr = NOP;
    logic        m_ifid_valid = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pending = 1'b0; m_discard = 1'b0; m_buf_valid = 1'b0;
        m_ifid_pc = '0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
        mem_pend = 1'b0; mem_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ifid_pc", IF_ID_PC, 32'h0);
        chk("rst_ifid_instr", IF_ID_Instr, NOP);
        chk("rst_ifid_valid", 32'(IF_ID_Valid), 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_fetch_busy", 32'(fetch_busy), 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle; entered and left at a falling edge.
    task automatic step(input logic pcw, input logic ifw, input logic fl,
                        input logic [31:0] bt, input logic rdy);
        logic        m_req, adv, got, have, inflight, acc;
        logic [31:0] ins, addr_s;
        PCWrite = pcw; IF_ID_Write = ifw; Flush = fl; BranchTarget = bt; imem_ready = rdy;
        if (mem_pend) begin
            imem_rvalid = (mem_cnt == 0);
            imem_rdata  = (mem_cnt == 0) ? instr_of(mem_a) : $urandom;
        end else begin
            imem_rvalid = stray_en && ($urandom_range(0, 3) == 0);
            imem_rdata  = $urandom;
        end
        #1;
        m_req = !m_pending && !m_buf_valid;
        chk("imem_req", 32'(imem_req), 32'(m_req));
        chk("fetch_busy", 32'(fetch_busy), 32'(m_pending));
        if (m_req) chk("imem_addr", imem_addr, m_pc);
        acc    = imem_req & imem_ready;
        addr_s = imem_addr;

        adv = pcw & ifw;
        got = m_pending & imem_rvalid;
        if (fl) begin
            inflight     = (m_pending && !imem_rvalid) || (m_req && rdy);
            m_ifid_pc    = m_pc; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
            m_pc         = bt;
            m_buf_valid  = 1'b0;
            m_pending    = inflight;
            m_discard    = inflight;
        end else begin
            have = 1'b0;
            ins  = '0;
            if (m_req && rdy) m_pending = 1'b1;
            if (got) begin
                m_pending = 1'b0;
                if (m_discard) m_discard = 1'b0;
                else begin have = 1'b1; ins = imem_rdata; end
            end else if (m_buf_valid) begin
                have = 1'b1; ins = m_buf;
            end
            if (have && adv) begin
                m_ifid_pc = m_pc; m_ifid_instr = ins; m_ifid_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_buf_valid = 1'b0;
            end else begin
                if (have) begin m_buf = ins; m_buf_valid = 1'b1; end
                if (ifw) begin m_ifid_pc = m_pc; m_ifid_instr = NOP; m_ifid_valid = 1'b0; end
            end
        end

        @(posedge clk);
        if (imem_rvalid && mem_pend) mem_pend = 1'b0;
        else if (mem_pend && mem_cnt > 0) mem_cnt--;
        if (acc) begin
            mem_pend = 1'b1;
            mem_a    = addr_s;
            mem_cnt  = $urandom_range(lat_lo, lat_hi);
        end
        #1;
        chk("ifid_pc", IF_ID_PC, m_ifid_pc);
        chk("ifid_instr", IF_ID_Instr, m_ifid_instr);
        chk("ifid_valid", 32'(IF_ID_Valid), 32'(m_ifid_valid));
        if (m_ifid_valid) chk("ifid_vs_mem", IF_ID_Instr, instr_of(m_ifid_pc));
        @(negedge clk);
    endtask

    initial begin
        logic        pcw, ifw, fl, rdy;
        logic [31:0] bt;
        int unsigned r;

        #1;
        do_reset();

        // steady stream, zero-wait memory
        lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < 5; i++) step(1, 1, 0, '0, 1);
        // stall while the response for 0x8 returns
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 1);
        step(1, 1, 0, '0, 1);
        chk("hold_release_pc", IF_ID_PC, 32'h8);
        chk("hold_release_valid", 32'(IF_ID_Valid), 32'h1);
        #1 chk("next_fetch_addr", imem_addr, 32'hC);

        // flush while waiting on a slow response
        lat_lo = 2; lat_hi = 2;
        step(1, 1, 0, '0, 1);
        step(1, 1, 1, 32'h100, 1);
        step(1, 1, 0, '0, 1);
        step(1, 1, 0, '0, 1);
        chk("flush_wait_valid", 32'(IF_ID_Valid), 32'h0);
        #1 chk("flush_wait_addr", imem_addr, 32'h100);

        // flush coinciding with the response
        lat_lo = 0; lat_hi = 0;
        step(1, 1, 0, '0, 1);
        step(1, 1, 1, 32'h200, 1);
        chk("flush_rvalid_valid", 32'(IF_ID_Valid), 32'h0);
        #1 chk("flush_rvalid_addr", imem_addr, 32'h200);

        // flush while stalled with a buffered instruction
        step(1, 1, 0, '0, 1);
        step(0, 0, 0, '0, 1);
        step(0, 1, 0, '0, 1);
        step(0, 0, 1, 32'h300, 1);
        chk("flush_hold_instr", IF_ID_Instr, NOP);
        #1 chk("flush_hold_addr", imem_addr, 32'h300);
        for (int i = 0; i < 2; i++) step(1, 1, 0, '0, 1);

        // memory not ready, then reset in the middle of a wait
        for (int i = 0; i < 4; i++) step(1, 1, 0, '0, 0);
        lat_lo = 3; lat_hi = 3;
        step(1, 1, 0, '0, 1);
        step(1, 1, 0, '0, 1);
        do_reset();
        lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 1);

        // randomized traffic
        lat_lo = 0; lat_hi = 3; stray_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else begin
                pcw = ($urandom_range(0, 3) != 0);
                ifw = ($urandom_range(0, 3) != 0);
                fl  = ($urandom_range(0, 9) == 0);
                rdy = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0:       bt = 32'hFFFF_FFFC;
                    1:       bt = $urandom;
                    default: bt = $urandom & 32'h0000_FFFC;
                endcase
                step(pcw, ifw, fl, bt, rdy);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: owns the PC, issues one-outstanding-request fetches to instruction memory, and drives the IF/ID pipeline register. It consumes PCWrite, IF_ID_Write and Flush from the hazard detection unit and BranchTarget from EX. It holds, replays or discards fetches so that stalls and flushes never lose or duplicate an instruction.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- PCWrite  in  1  0 = hold PC (HDU stall)
- IF_ID_Write  in  1  0 = hold IF/ID contents (HDU stall)
- Flush  in  1  redirect to BranchTarget, squash IF/ID
- BranchTarget  in  XLEN  redirect address, sampled when Flush=1
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (= PC while imem_req=1)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  fetched instruction
- IF_ID_PC  out  XLEN  PC of instruction in IF/ID
- IF_ID_Instr  out  32  instruction in IF/ID
- IF_ID_Valid  out  1  IF/ID holds a real instruction
- fetch_busy  out  1  request outstanding (state WAIT)

## Operation
- Delivery enable: adv = PCWrite & IF_ID_Write. Flush has priority over adv.
- States: REQ, WAIT, HOLD.
- REQ: imem_req=1, imem_addr=PC. imem_ready=1 -> WAIT.
- WAIT: imem_req=0. On imem_rvalid:
  - discard=1 -> clear discard, data dropped, -> REQ.
  - adv=1 -> IF/ID <= {PC, rdata, valid 1}, PC <= PC+4, -> REQ.
  - adv=0 -> rdata captured in hold buffer, -> HOLD.
- HOLD: imem_req=0. adv=1 -> IF/ID <= {PC, buffer, valid 1}, PC <= PC+4, -> REQ.
- No instruction available while IF_ID_Write=1 -> IF/ID <= bubble {PC, NOP 32'h0000_0013, valid 0}. IF_ID_Write=0 -> IF/ID holds.
- Flush=1, any state, regardless of PCWrite/IF_ID_Write:
  - PC <= BranchTarget.
  - IF/ID <= bubble.
  - Hold buffer invalidated.
  - Next state: WAIT with discard=1 if a request is in flight after this edge (state WAIT without rvalid, or REQ with imem_ready=1). Otherwise REQ.
- A response arriving in the same cycle as Flush is dropped.
- PC arithmetic is modulo 2^XLEN; PC[1:0] is passed through unchecked.

## Timing
- Reset (async assert): PC=RESET_PC, state=REQ, discard=0, IF_ID_PC=0, IF_ID_Instr=NOP, IF_ID_Valid=0, fetch_busy=0.
- imem_req=0 while reset is asserted; first request is in the first cycle after deassertion.
- Request accepted at edge k (imem_req & imem_ready). Memory returns rvalid no earlier than cycle k+1.
- Zero-wait memory: instruction visible in IF/ID after edge k+1. Throughput is 1 instruction per 2 cycles.
- All outputs are registered except imem_req, imem_addr and fetch_busy, which decode from state/PC.
- Reset mid-WAIT: the outstanding response is ignored. Memory must also be reset; discard is not used for this case.
- imem_rvalid outside WAIT is ignored.

## Structure
- Shared package riscv_pkg:
  - NOP constant 32'h0000_0013
  - fetch state enum {REQ, WAIT, HOLD}
  - default RESET_PC
- Sub-module if_id_reg holds {PC, Instr, Valid}. It has write enable, synchronous squash-to-bubble and async reset. It is reused by the decode stage register.

## Test plan
- Reset release, memory always ready, rvalid 1 cycle later -> imem_addr 0x0, 0x4, 0x8 on every other cycle; IF_ID_Valid=1 with matching PCs.
- PCWrite=IF_ID_Write=0 for 3 cycles while rvalid returns instr at 0x8 -> state HOLD; IF/ID unchanged; on release IF/ID={0x8, instr}; next fetch 0xC.
- Flush with BranchTarget=0x100 while in WAIT, rvalid 2 cycles later -> that response dropped; IF_ID_Valid=0; next request addr 0x100, no duplicate.
- Flush and imem_rvalid in the same cycle -> data dropped; next state REQ at BranchTarget; IF/ID bubble.
- Flush concurrent with stall (PCWrite=0) in HOLD -> buffer discarded; PC=BranchTarget; IF/ID bubble.
- imem_ready low for 4 cycles, then reset asserted mid-WAIT -> all outputs at reset values immediately; fetch restarts at RESET_PC.
